// File: rtl/h_rams_pkg.sv
// Shared types for the shared-RAM scheduler: FSM state, read-tracking pipe entry,
// and default-width address/data/id types for clients of the scheduler.
package h_rams_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  // Requester ids are carried at a fixed width so the pipe entry type is
  // independent of N_REQ; supports up to 256 requesters.
  localparam int unsigned MAX_ID_W   = 8;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [MAX_ID_W-1:0]   req_id_t;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } rd_pipe_t;

endpackage

// File: rtl/h_rams_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or
// above ptr, wrapping around to 0.
module h_rams_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int unsigned ID_W = $clog2(N);

  logic found;

  // First pass covers ptr..N-1, second pass wraps to 0..ptr-1.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/h_rams_sched.sv
// Round-robin scheduler sharing one single-port RAM among N_REQ requesters:
// zero-fills the array after reset, then issues one granted access per cycle.
module h_rams_sched
  import h_rams_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_vld,
  input  logic [N_REQ-1:0]         req_wr,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_gnt,
  output logic [N_REQ-1:0]         rsp_vld,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     init_done,
  output logic                     ram_en,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t              state_q;
  logic [CNT_W-1:0]    init_addr_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic                init_done_q;
  logic                ram_en_q;
  logic                ram_wen_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  rd_pipe_t            pipe_q [RD_LAT+1];

  logic [N_REQ-1:0]    arb_gnt;
  logic [ID_W-1:0]     gnt_id;
  logic                any_gnt;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  h_rams_rr_arb #(
    .N (N_REQ)
  ) u_arb (
    .req    (req_vld),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (gnt_id)
  );

  assign req_gnt = arb_gnt & {N_REQ{state_q == RUN}};
  assign any_gnt = |req_gnt;

  // One-hot mux of the granted requester's fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_gnt[i]) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      rr_ptr_q    <= '0;
      init_done_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      for (int j = 0; j <= RD_LAT; j++) pipe_q[j] <= '0;
    end else begin
      pipe_q[0] <= '{vld: any_gnt && !sel_wr, id: req_id_t'(gnt_id)};
      for (int j = RD_LAT; j > 0; j--) pipe_q[j] <= pipe_q[j-1];
      case (state_q)
        INIT: begin
          ram_en_q    <= 1'b1;
          ram_wen_q   <= 1'b1;
          ram_addr_q  <= init_addr_q[ADDR_W-1:0];
          ram_wdata_q <= '0;
          init_addr_q <= init_addr_q + CNT_W'(1);
          if (init_addr_q == {1'b0, {ADDR_W{1'b1}}}) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          ram_en_q  <= any_gnt;
          ram_wen_q <= any_gnt && sel_wr;
          if (any_gnt) begin
            ram_addr_q  <= sel_addr;
            ram_wdata_q <= sel_wdata;
            rr_ptr_q    <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Response decode from the pipe tail; data passes straight from the RAM.
  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_vld[i] = pipe_q[RD_LAT].vld && (pipe_q[RD_LAT].id == req_id_t'(i));
    end
  end

  assign rsp_rdata = ram_rdata;
  assign init_done = init_done_q;
  assign ram_en    = ram_en_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_h_rams_sched.sv
// Bench for h_rams_sched: RD_LAT=1 instance checked against a transaction-level
// scoreboard, RD_LAT=3 instance checked with hand-written sequences.
module tb_h_rams_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned RD1 = 1;
  localparam int unsigned RD3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // RD_LAT=1 instance
  logic              rst;
  logic [NR-1:0]     req_vld, req_wr, req_gnt, rsp_vld;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, ram_wdata, ram_rdata;
  logic              init_done, ram_en, ram_wen;
  logic [AW-1:0]     ram_addr;

  // RD_LAT=3 instance
  logic              rst3;
  logic [NR-1:0]     req_vld3, req_wr3, req_gnt3, rsp_vld3;
  logic [NR*AW-1:0]  req_addr3;
  logic [NR*DW-1:0]  req_wdata3;
  logic [DW-1:0]     rsp_rdata3, ram_wdata3, ram_rdata3;
  logic              init_done3, ram_en3, ram_wen3;
  logic [AW-1:0]     ram_addr3;

  h_rams_sched #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD1)) u_dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_gnt(req_gnt), .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata),
    .init_done(init_done), .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  h_rams_sched #(.N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_vld(req_vld3), .req_wr(req_wr3), .req_addr(req_addr3),
    .req_wdata(req_wdata3), .req_gnt(req_gnt3), .rsp_vld(rsp_vld3), .rsp_rdata(rsp_rdata3),
    .init_done(init_done3), .ram_en(ram_en3), .ram_wen(ram_wen3), .ram_addr(ram_addr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  // RAM models start with garbage so the zero-fill is observable.
  logic [DW-1:0] mem1 [16] = '{default: 32'hBAD0BAD0};
  logic [DW-1:0] mem3 [16] = '{default: 32'hBAD0BAD0};
  logic [DW-1:0] s0, s1;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen) mem1[ram_addr] <= ram_wdata;
      else         ram_rdata <= mem1[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (ram_en3) begin
      if (ram_wen3) mem3[ram_addr3] <= ram_wdata3;
      else          s0 <= mem3[ram_addr3];
    end
    s1         <= s0;
    ram_rdata3 <= s1;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard for the RD_LAT=1 instance
  typedef struct {
    int          due;
    int          id;
    logic [31:0] data;
  } exp_rsp_t;

  exp_rsp_t      rspq[$];
  logic [31:0]   m_mem [16];
  int            m_ptr;
  logic          exp_en, exp_wen;
  logic [3:0]    exp_addr;
  logic [31:0]   exp_wdata;

  logic          p_vld [NR];
  logic          p_wr [NR];
  logic [3:0]    p_addr [NR];
  logic [31:0]   p_wdata [NR];

  logic [NR-1:0] seen_gnt, seen_rsp;
  logic [31:0]   seen_rdata;

  // One cycle: drive pending requests, check against the scoreboard, advance.
  task automatic run_cycle();
    int eid;
    for (int i = 0; i < NR; i++) begin
      req_vld[i]             = p_vld[i];
      req_wr[i]              = p_wr[i];
      req_addr[i*AW +: AW]   = p_addr[i];
      req_wdata[i*DW +: DW]  = p_wdata[i];
    end
    #1;
    seen_gnt   = req_gnt;
    seen_rsp   = rsp_vld;
    seen_rdata = rsp_rdata;
    eid = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_ptr + k) % NR;
      if (eid < 0 && p_vld[idx]) eid = idx;
    end
    chk("gnt", 32'(req_gnt), (eid < 0) ? 32'd0 : (32'd1 << eid));
    chk("ram_en", 32'(ram_en), 32'(exp_en));
    if (exp_en) begin
      chk("ram_wen", 32'(ram_wen), 32'(exp_wen));
      chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
      if (exp_wen) chk("ram_wdata", ram_wdata, exp_wdata);
    end
    if (rspq.size() > 0 && rspq[0].due == cyc) begin
      chk("rsp_vld", 32'(rsp_vld), 32'd1 << rspq[0].id);
      chk("rsp_rdata", rsp_rdata, rspq[0].data);
      void'(rspq.pop_front());
    end else begin
      chk("rsp_vld_idle", 32'(rsp_vld), 32'd0);
    end
    if (eid >= 0) begin
      m_ptr     = (eid + 1) % NR;
      exp_en    = 1'b1;
      exp_wen   = p_wr[eid];
      exp_addr  = p_addr[eid];
      exp_wdata = p_wdata[eid];
      if (p_wr[eid]) m_mem[p_addr[eid]] = p_wdata[eid];
      else rspq.push_back('{due: cyc + 1 + int'(RD1), id: eid, data: m_mem[p_addr[eid]]});
      p_vld[eid] = 1'b0;
    end else begin
      exp_en = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic [3:0] vld;
    logic [3:0] wr;
    logic [3:0] exp_gnt;
  } tv_t;

  tv_t tv [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        got;

    tv[0]  = '{4'hF, 4'h0, 4'h1};  tv[1]  = '{4'hF, 4'h0, 4'h2};
    tv[2]  = '{4'hF, 4'h0, 4'h4};  tv[3]  = '{4'hF, 4'h0, 4'h8};
    tv[4]  = '{4'hF, 4'h0, 4'h1};  tv[5]  = '{4'h8, 4'h0, 4'h8};
    tv[6]  = '{4'h8, 4'h0, 4'h8};  tv[7]  = '{4'h8, 4'h0, 4'h8};
    tv[8]  = '{4'h8, 4'h0, 4'h8};  tv[9]  = '{4'h8, 4'h0, 4'h8};
    tv[10] = '{4'h1, 4'h0, 4'h1};  tv[11] = '{4'h0, 4'h0, 4'h0};
    tv[12] = '{4'h6, 4'h0, 4'h2};  tv[13] = '{4'h6, 4'h0, 4'h4};
    tv[14] = '{4'h5, 4'h1, 4'h1};  tv[15] = '{4'h5, 4'h0, 4'h4};

    rst = 1'b1;  rst3 = 1'b1;
    req_vld = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    req_vld3 = '0; req_wr3 = '0; req_addr3 = '0; req_wdata3 = '0;
    for (int i = 0; i < NR; i++) begin
      p_vld[i] = 1'b0; p_wr[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_wen", 32'(ram_wen), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_rsp_vld", 32'(rsp_vld), 0);
    chk("rst_gnt", 32'(req_gnt), 0);

    // Zero-fill with every requester pushing: no grant until init_done.
    rst = 1'b0;  rst3 = 1'b0;
    req_vld = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      chk("fill_en", 32'(ram_en), 1);
      chk("fill_wen", 32'(ram_wen), 1);
      chk("fill_addr", 32'(ram_addr), 32'(k - 1));
      chk("fill_wdata", ram_wdata, 0);
      chk("fill_init_done", 32'(init_done), (k == 16) ? 32'd1 : 32'd0);
      chk("fill_gnt", 32'(req_gnt), (k == 16) ? 32'd1 : 32'd0);
    end
    chk("fill_init_done3", 32'(init_done3), 1);
    req_vld = '0;
    @(posedge clk);
    #1;
    cyc = 17;
    m_ptr = 0;
    exp_en = 1'b0; exp_wen = 1'b0; exp_addr = '0; exp_wdata = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;

    // Table-driven arbitration vectors; requests held as given each cycle.
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < NR; i++) begin
        p_vld[i]   = tv[r].vld[i];
        p_wr[i]    = tv[r].wr[i];
        p_addr[i]  = 4'((r + i) % 16);
        p_wdata[i] = $urandom;
      end
      run_cycle();
      chk("tbl_gnt", 32'(seen_gnt), 32'(tv[r].exp_gnt));
    end
    for (int i = 0; i < NR; i++) p_vld[i] = 1'b0;
    repeat (4) run_cycle();

    // Write then read back through a different requester.
    p_vld[2] = 1'b1; p_wr[2] = 1'b1; p_addr[2] = 4'hA; p_wdata[2] = 32'hDEADBEEF;
    for (int t = 0; t < 8 && p_vld[2]; t++) run_cycle();
    chk("wr_granted", 32'(p_vld[2]), 0);
    p_vld[1] = 1'b1; p_wr[1] = 1'b0; p_addr[1] = 4'hA;
    got = 1'b0; d = '0;
    for (int t = 0; t < 10 && !got; t++) begin
      run_cycle();
      if (seen_rsp[1]) begin got = 1'b1; d = seen_rdata; end
    end
    chk("rd_after_wr_seen", 32'(got), 1);
    chk("rd_after_wr_data", d, 32'hDEADBEEF);

    // Address never written since the fill reads back zero.
    p_vld[0] = 1'b1; p_wr[0] = 1'b0; p_addr[0] = 4'hF;
    got = 1'b0; d = 32'hFFFFFFFF;
    for (int t = 0; t < 10 && !got; t++) begin
      run_cycle();
      if (seen_rsp[0]) begin got = 1'b1; d = seen_rdata; end
    end
    chk("rd_unwritten_seen", 32'(got), 1);
    chk("rd_unwritten_data", d, 0);

    // Read and write to the same address presented together.
    p_vld[0] = 1'b1; p_wr[0] = 1'b0; p_addr[0] = 4'h7;
    p_vld[1] = 1'b1; p_wr[1] = 1'b1; p_addr[1] = 4'h7; p_wdata[1] = 32'h0BADF00D;
    for (int t = 0; t < 6; t++) run_cycle();

    // Randomized traffic with the valid/grant handshake.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!p_vld[i] && $urandom_range(0, 99) < 60) begin
          p_vld[i]   = 1'b1;
          p_wr[i]    = 1'($urandom_range(0, 1));
          p_addr[i]  = 4'($urandom_range(0, 15));
          p_wdata[i] = $urandom;
        end
      end
      run_cycle();
    end
    for (int i = 0; i < NR; i++) p_vld[i] = 1'b0;
    repeat (6) run_cycle();
    chk("rspq_drained", 32'(rspq.size()), 0);

    // RD_LAT=3: a write, then back-to-back reads from requesters 0 and 1.
    req_vld3 = 4'b0100; req_wr3 = 4'b0100;
    req_addr3[2*AW +: AW] = 4'h5; req_wdata3[2*DW +: DW] = 32'h11111111;
    #1 chk("d3_wr_gnt", 32'(req_gnt3), 32'h4);
    @(posedge clk); #1;
    req_vld3 = 4'b0011; req_wr3 = '0;
    req_addr3[0 +: AW] = 4'h5; req_addr3[AW +: AW] = 4'h6;
    #1 chk("d3_rd0_gnt", 32'(req_gnt3), 32'h1);
    @(posedge clk); #1;
    req_vld3 = 4'b0010;
    #1 chk("d3_rd1_gnt", 32'(req_gnt3), 32'h2);
    @(posedge clk); #1;
    req_vld3 = '0;
    for (int t = 2; t <= 7; t++) begin
      #1;
      chk("d3_rsp_vld", 32'(rsp_vld3), (t == 4) ? 32'h1 : (t == 5) ? 32'h2 : 32'h0);
      if (t == 4) chk("d3_rsp0_data", rsp_rdata3, 32'h11111111);
      if (t == 5) chk("d3_rsp1_data", rsp_rdata3, 32'h0);
      @(posedge clk); #1;
    end

    // Reset while two reads are in flight: responses dropped, fill restarts.
    req_vld3 = 4'b0011;
    #1 chk("d3r_gnt0", 32'(req_gnt3), 32'h1);
    @(posedge clk); #1;
    req_vld3 = 4'b0010;
    #1 chk("d3r_gnt1", 32'(req_gnt3), 32'h2);
    @(posedge clk); #1;
    req_vld3 = '0; rst3 = 1'b1;
    #1 chk("d3r_rsp_pre", 32'(rsp_vld3), 0);
    @(posedge clk); #1;
    rst3 = 1'b0; req_vld3 = 4'hF;
    #1;
    chk("d3r_ram_en", 32'(ram_en3), 0);
    chk("d3r_init_done", 32'(init_done3), 0);
    chk("d3r_rsp", 32'(rsp_vld3), 0);
    chk("d3r_gnt", 32'(req_gnt3), 0);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("d3r_refill_rsp", 32'(rsp_vld3), 0);
      chk("d3r_refill_addr", 32'(ram_addr3), 32'(k - 1));
      chk("d3r_refill_wen", 32'(ram_wen3), 1);
      chk("d3r_refill_gnt", 32'(req_gnt3), 0);
      chk("d3r_refill_done", 32'(init_done3), 0);
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
